// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared constants for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit full adder from two half adders and an OR for the carry.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0, c0, c1;

    half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));

    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// half_adder: one-bit half adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder with valid/ready handshakes on both sides.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output out_ovf.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [CW-1:0]    cnt;
    logic             carry, s, c, last;

    full_adder_cell u_cell (.a(a_sr[0]), .b(b_sr[0]), .cin(carry), .sum(s), .cout(c));

    assign last      = cnt == CW'(WIDTH - 1);
    assign in_ready  = state == ST_IDLE;
    assign out_valid = state == ST_DONE;
    assign busy      = state != ST_IDLE;

    // out_sum doubles as the sum shift register; it settles on the final RUN edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            a_sr  <= in_a;
            b_sr  <= in_b;
            carry <= in_cin;
            cnt   <= '0;
            state <= ST_RUN;
        end else if (state == ST_RUN) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            carry   <= c;
            cnt     <= cnt + 1'b1;
            out_sum <= {s, out_sum[WIDTH-1:1]};
            if (last) begin
                out_cout <= c;
                state    <= ST_DONE;
            end
        end else if (state == ST_DONE && out_ready) begin
            state <= ST_IDLE;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // on the final bit, carry holds the carry into the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_ovf <= 1'b0;
        else if (state == ST_RUN && last)
            out_ovf <= carry ^ c;
    end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and back-to-back checks of serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    logic       clk, rst_n, in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
    logic [7:0] in_a, in_b, out_sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic       out_ovf;
`endif
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
`ifdef SERIAL_ADDER_OVF_EN
        .out_ovf(out_ovf),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_ready"}, in_ready, 1'b1);
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin);
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        in_cin = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
        wait_ready(tag);
        issue(a, b, cin);
        chk({tag, "_busy"}, busy, 1'b1);
        wait_valid(tag, 8);
        chk({tag, "_sum"}, out_sum, exp_sum);
        chk({tag, "_cout"}, out_cout, exp_cout);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        int last_acc;
        logic [8:0] ref_sum;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        in_cin = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sum", out_sum, 8'h00);
        chk("rst_cout", out_cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", out_ovf, 1'b0);
`endif
        #2 rst_n = 1'b1;
        step();

        run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        drain();
        chk("zero_idle", in_ready, 1'b1);
        run_op("ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        drain();
        chk("ff01_hold_sum", out_sum, 8'h00);
        run_op("a55a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        drain();
        run_op("mix", 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0);
        drain();
`ifdef SERIAL_ADDER_OVF_EN
        run_op("ovf7f", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        chk("ovf7f_ovf", out_ovf, 1'b1);
        drain();
        run_op("ovf80", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1);
        chk("ovf80_ovf", out_ovf, 1'b1);
        drain();
        run_op("noovf", 8'h01, 8'hFF, 1'b0, 8'h00, 1'b1);
        chk("noovf_ovf", out_ovf, 1'b0);
        drain();
`endif

        // backpressure in DONE with a competing in_valid
        run_op("bp", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
        in_a = 8'h11;
        in_b = 8'h22;
        in_cin = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_sum", out_sum, 8'h4B);
            chk("bp_cout", out_cout, 1'b0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_rel_valid", out_valid, 1'b0);
        chk("bp_rel_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("bp_acc_busy", busy, 1'b1);
        chk("bp_acc_ready", in_ready, 1'b0);
        wait_valid("bp2", 8);
        chk("bp2_sum", out_sum, 8'h33);
        chk("bp2_cout", out_cout, 1'b0);
        drain();

        // reset mid-RUN discards the operation
        wait_ready("rst_mid");
        issue(8'hF0, 8'h0F, 1'b0);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", in_ready, 1'b1);
        chk("abort_sum", out_sum, 8'h00);
        chk("abort_cout", out_cout, 1'b0);
        step();
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        chk("abort_sum2", out_sum, 8'h00);
        run_op("post_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        drain();

        // back-to-back with in_valid held high
        out_ready = 1'b1;
        in_valid = 1'b1;
        last_acc = -1;
        for (int i = 0; i < 100; i++) begin
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            in_cin = 1'($urandom);
            ref_sum = {1'b0, in_a} + {1'b0, in_b} + {8'h00, in_cin};
            wait_ready("b2b");
            if (last_acc >= 0) chk("b2b_interval", cyc - last_acc, 10);
            last_acc = cyc;
            step();
            wait_valid("b2b", 8);
            chk("b2b_sum", {out_cout, out_sum}, ref_sum);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add controller that sequences a single one-bit full-adder cell, itself built from two `half_adder` instances, across WIDTH cycles to produce a WIDTH-bit sum. It sits between an operand producer and a result consumer in the 8-bit adder project, with valid/ready handshakes on both sides. It trades throughput for area: one operation is in flight at a time, and no parallel carry chain is used.

## Interface
- `WIDTH`, default 8: operand/sum width in bits; legal range 2..32.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operands present on `in_a`, `in_b`, `in_cin`.
- `in_ready`  out  1: block can accept an operation.
- `in_a`  in  WIDTH: augend.
- `in_b`  in  WIDTH: addend.
- `in_cin`  in  1: carry-in.
- `out_valid`  out  1: result present.
- `out_ready`  in  1: consumer accepts the result.
- `out_sum`  out  WIDTH: sum bits.
- `out_cout`  out  1: carry-out of the MSB.
- `busy`  out  1: operation in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: capture `in_a`→A shift reg, `in_b`→B shift reg, `in_cin`→carry reg, clear bit counter, go to RUN.
- RUN, each cycle:
  - Cell computes s = A[0]^B[0]^carry and c = majority(A[0],B[0],carry).
  - s is shifted into the sum register at the MSB; the sum register shifts right.
  - A and B shift right; carry←c; counter increments.
  - When counter == WIDTH-1, go to DONE after this update.
- DONE:
  - `out_valid`=1; `out_sum` and `out_cout` are held stable.
  - On `out_ready`, go to IDLE.
- `in_ready` and `out_valid` are decodes of state: `in_ready` = (state==IDLE), `out_valid` = (state==DONE), `busy` = !IDLE.
- Arithmetic: {`out_cout`,`out_sum`} = `in_a` + `in_b` + `in_cin`, computed at WIDTH+1 bits, unsigned.
- Boundary rules:
  - `in_valid` is ignored outside IDLE; operands need not be held after acceptance.
  - Result registers keep their last value after the output handshake. They are meaningful only while `out_valid`=1.
  - Handshake on the same cycle as DONE→IDLE with `in_valid`=1: not accepted, because `in_ready`=0 in DONE. The new operation is accepted on the next cycle.
  - Reset asserted at any point (mid-RUN included) aborts the operation. The in-flight result is discarded and never presented.
- Reset values:
  - State IDLE; all shift registers, counter, carry, `out_sum`, `out_cout` = 0.
  - `out_valid`=0, `busy`=0, `in_ready`=1.

## Timing
- Acceptance edge E0 → `out_valid` high after edge E0+WIDTH, i.e. latency WIDTH cycles (8 for the default).
- Minimum issue interval: WIDTH+2 cycles (RUN for WIDTH, DONE for 1, IDLE for 1).
- No combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`.

## Configuration
- `SERIAL_ADDER_OVF_EN` defined:
  - Adds output `out_ovf` (1 bit): signed overflow = carry into MSB XOR `out_cout`.
  - It is captured on the final RUN cycle, held with `out_sum`, and resets to 0.
- Macro undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `serial_adder_pkg`:
  - FSM state enum (IDLE, RUN, DONE).
  - Default WIDTH constant.
  - Counter width function/constant: clog2(WIDTH).
- Sub-module `full_adder_cell`:
  - Two `half_adder` instances plus an OR for carry.
  - Ports a, b, cin, sum, cout; purely combinational.
  - Instanced once in `serial_adder_ctrl`.

## Test plan
- 0x00+0x00, cin=0 → `out_sum`=0x00, `out_cout`=0, `out_valid` exactly 8 cycles after acceptance.
- 0xFF+0x01, cin=0 → 0x00, cout=1; 0xA5+0x5A, cin=1 → 0x00, cout=1.
- With `SERIAL_ADDER_OVF_EN`: 0x7F+0x01 → 0x80, `out_ovf`=1; 0x80+0xFF → 0x7F, cout=1, `out_ovf`=1.
- Backpressure: `out_ready`=0 for 5 cycles in DONE with `in_valid`=1 → `out_sum`/`out_cout` stable, `in_ready`=0, no new capture. Release → IDLE, new operation accepted one cycle later.
- Reset pulse at RUN cycle 4 of 0xF0+0x0F → `out_valid` never asserts, outputs 0, `in_ready`=1. Next 0x12+0x34 → 0x46, cout=0.
- Back-to-back: `in_valid` held high with random operands over 100 operations, `out_ready`=1 → every result matches the reference sum; issue interval = 10 cycles.
